conway_serial_host: RTL and testbench
=====================================

Name: conway_serial_host

Overview:
- Host-side initiator that drives one conway_8x8_serial_v4 target over its serial/mode pins.
- Accepts a 64-bit board, a generation count and a start pulse from system logic, then sequences the target through load, run and output.
- Shifts the board in and captures the resulting 64-bit board back, then reports done.
- Shares `clk` with the target. All target-facing outputs are registered.

Parameters:
- DATA_SIZE, 64, board bits; must equal GRID_WIDTH*GRID_HEIGHT of the target.
- GEN_WIDTH, 16, width of the generation counter.

Ports:
- clk  input  1  system clock, shared with the target.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request; sampled only in IDLE.
- board_in  input  DATA_SIZE  initial board; bit index = row*8+col.
- gen_count  input  GEN_WIDTH  generations to run; 0 is legal.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when board_out is valid.
- board_out  output  DATA_SIZE  captured board; held until the next done.
- tgt_mode  output  2  drives target mode: 00 stop, 01 load, 10 run, 11 output.
- tgt_data_in  output  1  drives target data_in.
- tgt_data_out  input  1  target data_out.

Behaviour:
- Reset:
  - FSM goes to IDLE; tgt_mode=00; tgt_data_in=0; busy=0; done=0; board_out=0.
  - All counters are cleared.
- States: IDLE, LOAD, RUN, UNLOAD, DONE.
- IDLE:
  - tgt_mode=00.
  - When start=1, latch board_in into a DATA_SIZE shift register and latch gen_count. Next state is LOAD.
- LOAD, exactly DATA_SIZE cycles:
  - tgt_mode=01.
  - tgt_data_in = current MSB of the shift register; shift left by 1 each cycle. Bit 63 is sent first.
  - Bit counter runs 0..DATA_SIZE-1.
  - On the last bit: go to RUN if the latched gen_count≠0, else go to UNLOAD.
- RUN, exactly gen_count cycles:
  - tgt_mode=10; tgt_data_in=0.
  - The generation counter decrements once per cycle; when it reaches 1, the next state is UNLOAD.
- UNLOAD, exactly DATA_SIZE cycles:
  - tgt_mode=11.
  - Each cycle, shift tgt_data_out into the LSB of the capture register. The first bit captured is target bit 63, so after 64 shifts the capture register holds the board in natural order.
  - The target presents its MSB combinationally on data_out while in output mode. No extra pipeline stage on the capture path.
- DONE, 1 cycle:
  - tgt_mode=00.
  - board_out <= capture register; done=1; busy=0 in the same cycle.
  - Next state is IDLE.
- Bit count is invariant: every job shifts exactly DATA_SIZE bits in and DATA_SIZE bits out, as the target memory requires.
- Latency: start accepted at edge T; done is high in cycle T + 2*DATA_SIZE + N + 1, where N = gen_count.
- Boundary conditions:
  - start while busy: ignored; no queueing; the latched inputs are unchanged.
  - board_in or gen_count changing mid-job: no effect.
  - gen_count = 2^GEN_WIDTH-1: full count with no wrap; the counter is GEN_WIDTH bits and is compared against 1.
  - start in the DONE cycle: ignored; it is accepted only in IDLE.
  - reset asserted mid-operation: immediate return to IDLE and tgt_mode=00. The target board is undefined afterwards; the next job reloads it fully. board_out clears to 0.
  - tgt_mode 00 is never issued between LOAD/RUN/UNLOAD within a job; transitions are direct.

Decomposition:
- Shared package conway_pkg:
  - mode_t enum: MODE_STOP=2'b00, MODE_LOAD=2'b01, MODE_RUN=2'b10, MODE_OUTPUT=2'b11. The target decoder uses the same enum.
  - DATA_SIZE default constant.
  - host_state_t enum.
- Sub-module serial_shifter (parameter WIDTH): a parallel-load PISO/SIPO register with load, shift_en, ser_in and ser_out. One instance serves both directions, since LOAD and UNLOAD are disjoint. board_out is a separate holding register.

Test Plan:
- Blinker: board_in=0x0000_0000_1C00_0000, gen_count=1 -> done at T+130; board_out=0x0000_0008_0808_0000.
- Zero generations: board_in=0xDEAD_BEEF_0123_4567, gen_count=0 -> RUN skipped; done at T+129; board_out=board_in.
- Block still life: board_in=0x0000_0018_1800_0000, gen_count=5 -> board_out unchanged.
- Protocol checker:
  - tgt_mode stays 01 for exactly 64 cycles, 10 for exactly N cycles, and 11 for exactly 64 cycles.
  - tgt_data_in in the first LOAD cycle equals board_in[63].
  - busy and done are never high together.
- Reset mid-RUN:
  - Drive reset=0 in cycle T+80 of a gen_count=20 job -> asynchronously tgt_mode=00, busy=0, board_out=0.
  - A following blinker job still returns 0x0000_0008_0808_0000.
- start pulses in cycles T+10 and in the DONE cycle -> ignored; exactly one done; board_out matches the first job.

Source files
------------

// File: rtl/conway_pkg.sv
// Shared types and defaults for the Conway 8x8 serial host and its target.
// Contents: default board/generation-counter widths, the target mode
// encoding, the host FSM state enum and a state-to-mode mapping helper.
package conway_pkg;

    localparam int unsigned DATA_SIZE_DEF = 64;
    localparam int unsigned GEN_WIDTH_DEF = 16;

    // Target mode pins; the target-side decoder uses the same encoding.
    typedef enum logic [1:0] {
        MODE_STOP   = 2'b00,
        MODE_LOAD   = 2'b01,
        MODE_RUN    = 2'b10,
        MODE_OUTPUT = 2'b11
    } mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_UNLOAD,
        ST_DONE
    } host_state_t;

    // Mode the target must see while the host sits in a given state.
    function automatic mode_t state_mode(input host_state_t s);
        case (s)
            ST_LOAD:   return MODE_LOAD;
            ST_RUN:    return MODE_RUN;
            ST_UNLOAD: return MODE_OUTPUT;
            default:   return MODE_STOP;
        endcase
    endfunction

endpackage

// File: rtl/serial_shifter.sv
// Parallel-load shift register usable as PISO (load, then shift out of the
// MSB) or SIPO (shift in at the LSB, read in parallel).
// Ports:
//   clk, rst_n        clock, async active-low reset
//   i_load, i_par     parallel load (has priority over shifting)
//   i_shift_en        shift left by one, i_ser_in enters at the LSB
//   o_ser_out         current MSB
//   o_par             full register contents
module serial_shifter #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_par,
    input  logic             i_shift_en,
    input  logic             i_ser_in,
    output logic             o_ser_out,
    output logic [WIDTH-1:0] o_par
);

    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_par;
        end else if (i_shift_en) begin
            r_data <= {r_data[WIDTH-2:0], i_ser_in};
        end
    end

    assign o_ser_out = r_data[WIDTH-1];
    assign o_par     = r_data;

endmodule

// File: rtl/conway_serial_host.sv
// Host-side initiator for one conway_8x8_serial_v4 target: loads a board,
// runs gen_count generations and reads the resulting board back.
// Ports:
//   clk, reset            shared clock, async active-low reset
//   start                 job request, honoured only in IDLE
//   board_in, gen_count   job inputs, latched on an accepted start
//   busy, done            job in flight / one-cycle result-valid pulse
//   board_out             last captured board, held until the next done
//   tgt_mode              target mode pins (stop/load/run/output)
//   tgt_data_in           serial data to the target
//   tgt_data_out          serial data from the target (combinational MSB)
module conway_serial_host
    import conway_pkg::*;
#(
    parameter int unsigned DATA_SIZE = DATA_SIZE_DEF,
    parameter int unsigned GEN_WIDTH = GEN_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [DATA_SIZE-1:0] board_in,
    input  logic [GEN_WIDTH-1:0] gen_count,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_SIZE-1:0] board_out,
    output logic [1:0]           tgt_mode,
    output logic                 tgt_data_in,
    input  logic                 tgt_data_out
);

    localparam int unsigned CNT_W = $clog2(DATA_SIZE);

    host_state_t          r_state,   w_state_nxt;
    logic [CNT_W-1:0]     r_bit_cnt, w_bit_cnt_nxt;
    logic [GEN_WIDTH-1:0] r_gen_cnt, w_gen_cnt_nxt;
    mode_t                r_mode,    w_mode_nxt;
    logic                 r_data_in, w_data_in_nxt;
    logic                 r_busy,    w_busy_nxt;
    logic                 r_done,    w_done_nxt;
    logic [DATA_SIZE-1:0] r_board,   w_board_nxt;

    logic                 w_sh_load;
    logic                 w_sh_shift;
    logic                 w_ser_out;
    logic [DATA_SIZE-1:0] w_sh_par;
    logic [DATA_SIZE-1:0] w_sh_q;
    logic                 w_last_bit;

    // Bit 63 goes straight to tgt_data_in on accept, so the shifter is
    // preloaded one position ahead and its MSB is always the next bit to send.
    assign w_sh_par   = {board_in[DATA_SIZE-2:0], 1'b0};
    assign w_last_bit = (r_bit_cnt == CNT_W'(DATA_SIZE - 1));

    // Single shifter: sends during LOAD, captures tgt_data_out during UNLOAD.
    serial_shifter #(
        .WIDTH (DATA_SIZE)
    ) u_shifter (
        .clk        (clk),
        .rst_n      (reset),
        .i_load     (w_sh_load),
        .i_par      (w_sh_par),
        .i_shift_en (w_sh_shift),
        .i_ser_in   (tgt_data_out),
        .o_ser_out  (w_ser_out),
        .o_par      (w_sh_q)
    );

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_gen_cnt_nxt = r_gen_cnt;
        w_data_in_nxt = 1'b0;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_board_nxt   = r_board;
        w_sh_load     = 1'b0;
        w_sh_shift    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt   = ST_LOAD;
                    w_sh_load     = 1'b1;
                    w_gen_cnt_nxt = gen_count;
                    w_bit_cnt_nxt = '0;
                    w_data_in_nxt = board_in[DATA_SIZE-1];
                    w_busy_nxt    = 1'b1;
                end
            end
            ST_LOAD: begin
                w_sh_shift = 1'b1;
                if (w_last_bit) begin
                    w_bit_cnt_nxt = '0;
                    w_state_nxt   = (r_gen_cnt != '0) ? ST_RUN : ST_UNLOAD;
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                    w_data_in_nxt = w_ser_out;
                end
            end
            ST_RUN: begin
                w_gen_cnt_nxt = r_gen_cnt - GEN_WIDTH'(1);
                if (r_gen_cnt == GEN_WIDTH'(1)) begin
                    w_state_nxt = ST_UNLOAD;
                end
            end
            ST_UNLOAD: begin
                w_sh_shift = 1'b1;
                if (w_last_bit) begin
                    w_bit_cnt_nxt = '0;
                    w_state_nxt   = ST_DONE;
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                w_board_nxt = w_sh_q;
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Mode follows the next state so the pins change on the same edge.
        w_mode_nxt = state_mode(w_state_nxt);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_gen_cnt <= '0;
            r_mode    <= MODE_STOP;
            r_data_in <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_board   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_gen_cnt <= w_gen_cnt_nxt;
            r_mode    <= w_mode_nxt;
            r_data_in <= w_data_in_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_board   <= w_board_nxt;
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign board_out   = r_board;
    assign tgt_mode    = r_mode;
    assign tgt_data_in = r_data_in;

endmodule

// File: tb/tb_conway_serial_host.sv
// Bench for conway_serial_host with a behavioural 8x8 Life target attached.
// Timing convention: edge T is the clock edge that samples start; a result
// is observed just after edge T + 129 + gen_count.
module tb_conway_serial_host;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [63:0] board_in;
    logic [15:0] gen_count;
    logic        busy;
    logic        done;
    logic [63:0] board_out;
    logic [1:0]  tgt_mode;
    logic        tgt_data_in;
    logic        tgt_data_out;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc   = 0;

    typedef struct {
        logic [63:0] board;
        int unsigned lat;
    } exp_t;
    exp_t sb[$];

    conway_serial_host dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .board_in     (board_in),
        .gen_count    (gen_count),
        .busy         (busy),
        .done         (done),
        .board_out    (board_out),
        .tgt_mode     (tgt_mode),
        .tgt_data_in  (tgt_data_in),
        .tgt_data_out (tgt_data_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // One Life generation on an 8x8 board with dead cells outside the edge.
    function automatic logic [63:0] life_step(input logic [63:0] b);
        logic [63:0] nb;
        int n, rr, cc;
        nb = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
                        if (!(dr == 0 && dc == 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
                            n += int'(b[rr*8+cc]);
                    end
                end
                nb[r*8+c] = (n == 3) || (b[r*8+c] && n == 2);
            end
        end
        return nb;
    endfunction

    // Behavioural target: shift-in on load, step on run, shift-out on output.
    logic [63:0] tgt_mem = '0;
    assign tgt_data_out = (tgt_mode == 2'b11) ? tgt_mem[63] : 1'b0;
    always @(posedge clk) begin
        case (tgt_mode)
            2'b01:   tgt_mem <= {tgt_mem[62:0], tgt_data_in};
            2'b10:   tgt_mem <= life_step(tgt_mem);
            2'b11:   tgt_mem <= {tgt_mem[62:0], 1'b0};
            default: ;
        endcase
    end

    // Protocol monitor: lengths of completed mode runs, first LOAD bit, overlaps.
    logic [1:0]  mon_prev = 2'b00;
    int unsigned mon_len  = 0;
    int unsigned run_len[4] = '{default: 0};
    int unsigned run_cnt[4] = '{default: 0};
    logic        first_bit = 1'b0;
    int unsigned overlap = 0;
    int unsigned done_pulses = 0;
    always @(negedge clk) begin
        if (busy && done) overlap++;
        if (done) done_pulses++;
        if (tgt_mode == mon_prev) begin
            mon_len++;
        end else begin
            run_len[mon_prev] = mon_len;
            run_cnt[mon_prev]++;
            if (tgt_mode == 2'b01) first_bit = tgt_data_in;
            mon_prev = tgt_mode;
            mon_len  = 1;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic launch(input logic [63:0] b, input logic [15:0] n,
                          input logic [63:0] exp_b, output int unsigned t0);
        exp_t e;
        e.board = exp_b;
        e.lat   = 129 + int'(n);
        sb.push_back(e);
        board_in  = b;
        gen_count = n;
        start     = 1'b1;
        step();
        start = 1'b0;
        t0    = cyc;
    endtask

    task automatic wait_done(input int unsigned budget, output bit seen);
        seen = 1'b0;
        for (int unsigned i = 0; i < budget && !seen; i++) begin
            step();
            if (done) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; board_in = '0; gen_count = '0;
        step(); step();
        n_cmp++; if (tgt_mode !== 2'b00) begin n_bad++; $display("FAIL reset_mode: got %b expected 00", tgt_mode); end
        n_cmp++; if (tgt_data_in !== 1'b0) begin n_bad++; $display("FAIL reset_data_in: got %b expected 0", tgt_data_in); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (board_out !== 64'h0) begin n_bad++; $display("FAIL reset_board: got %h expected 0", board_out); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_blinker();
        int unsigned t0;
        bit seen;
        exp_t e;
        int unsigned c2;
        c2 = run_cnt[2];
        launch(64'h0000_0000_1C00_0000, 16'd1, 64'h0000_0008_0808_0000, t0);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL blinker_busy: got %b expected 1", busy); end
        n_cmp++; if (tgt_mode !== 2'b01) begin n_bad++; $display("FAIL blinker_mode_load: got %b expected 01", tgt_mode); end
        wait_done(400, seen);
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL blinker_done_timeout: got none expected done"); end
        e = sb.pop_front();
        n_cmp++; if (cyc - t0 !== e.lat) begin n_bad++; $display("FAIL blinker_latency: got %0d expected %0d", cyc - t0, e.lat); end
        n_cmp++; if (board_out !== e.board) begin n_bad++; $display("FAIL blinker_board: got %h expected %h", board_out, e.board); end
        n_cmp++; if (run_len[1] !== 64) begin n_bad++; $display("FAIL blinker_load_len: got %0d expected 64", run_len[1]); end
        n_cmp++; if (run_len[2] !== 1 || run_cnt[2] !== c2 + 1) begin n_bad++; $display("FAIL blinker_run_len: got %0d expected 1", run_len[2]); end
        n_cmp++; if (run_len[3] !== 64) begin n_bad++; $display("FAIL blinker_unload_len: got %0d expected 64", run_len[3]); end
        step();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL blinker_done_pulse: got %b expected 0", done); end
        n_cmp++; if (board_out !== 64'h0000_0008_0808_0000) begin n_bad++; $display("FAIL blinker_hold: got %h expected 0000000808080000", board_out); end
    endtask

    task automatic test_zero_gen();
        int unsigned t0;
        bit seen;
        exp_t e;
        int unsigned c2;
        logic [63:0] b;
        b  = 64'hDEAD_BEEF_0123_4567;
        c2 = run_cnt[2];
        launch(b, 16'd0, b, t0);
        n_cmp++; if (tgt_data_in !== b[63]) begin n_bad++; $display("FAIL zero_first_bit: got %b expected %b", tgt_data_in, b[63]); end
        wait_done(400, seen);
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL zero_done_timeout: got none expected done"); end
        e = sb.pop_front();
        n_cmp++; if (cyc - t0 !== e.lat) begin n_bad++; $display("FAIL zero_latency: got %0d expected %0d", cyc - t0, e.lat); end
        n_cmp++; if (board_out !== e.board) begin n_bad++; $display("FAIL zero_board: got %h expected %h", board_out, e.board); end
        n_cmp++; if (run_cnt[2] !== c2) begin n_bad++; $display("FAIL zero_run_skipped: got %0d runs expected %0d", run_cnt[2], c2); end
        n_cmp++; if (first_bit !== b[63]) begin n_bad++; $display("FAIL zero_mon_first_bit: got %b expected %b", first_bit, b[63]); end
    endtask

    task automatic test_block();
        int unsigned t0;
        bit seen;
        exp_t e;
        launch(64'h0000_0018_1800_0000, 16'd5, 64'h0000_0018_1800_0000, t0);
        wait_done(400, seen);
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL block_done_timeout: got none expected done"); end
        e = sb.pop_front();
        n_cmp++; if (cyc - t0 !== e.lat) begin n_bad++; $display("FAIL block_latency: got %0d expected %0d", cyc - t0, e.lat); end
        n_cmp++; if (board_out !== e.board) begin n_bad++; $display("FAIL block_board: got %h expected %h", board_out, e.board); end
        n_cmp++; if (run_len[2] !== 5) begin n_bad++; $display("FAIL block_run_len: got %0d expected 5", run_len[2]); end
    endtask

    task automatic test_random();
        int unsigned t0;
        bit seen;
        exp_t e;
        logic [63:0] b, x;
        logic [15:0] n;
        for (int k = 0; k < 3; k++) begin
            b = {$urandom, $urandom};
            n = 16'($urandom_range(2, 12));
            x = b;
            for (int g = 0; g < int'(n); g++) x = life_step(x);
            launch(b, n, x, t0);
            wait_done(400, seen);
            n_cmp++; if (!seen) begin n_bad++; $display("FAIL random_done_timeout: got none expected done"); end
            e = sb.pop_front();
            n_cmp++; if (board_out !== e.board) begin n_bad++; $display("FAIL random_board: got %h expected %h", board_out, e.board); end
            n_cmp++; if (cyc - t0 !== e.lat) begin n_bad++; $display("FAIL random_latency: got %0d expected %0d", cyc - t0, e.lat); end
        end
    endtask

    task automatic test_reset_mid_run();
        int unsigned t0;
        bit seen;
        exp_t e;
        launch(64'h0123_4567_89AB_CDEF, 16'd20, 64'h0, t0);
        for (int i = 0; i < 200 && (cyc - t0) < 80; i++) step();
        n_cmp++; if (tgt_mode !== 2'b10) begin n_bad++; $display("FAIL midrun_mode_before: got %b expected 10", tgt_mode); end
        reset = 1'b0;
        #1;
        n_cmp++; if (tgt_mode !== 2'b00) begin n_bad++; $display("FAIL midrun_reset_mode: got %b expected 00", tgt_mode); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrun_reset_busy: got %b expected 0", busy); end
        n_cmp++; if (board_out !== 64'h0) begin n_bad++; $display("FAIL midrun_reset_board: got %h expected 0", board_out); end
        void'(sb.pop_front());
        step();
        reset = 1'b1;
        step();
        launch(64'h0000_0000_1C00_0000, 16'd1, 64'h0000_0008_0808_0000, t0);
        wait_done(400, seen);
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL midrun_next_timeout: got none expected done"); end
        e = sb.pop_front();
        n_cmp++; if (board_out !== e.board) begin n_bad++; $display("FAIL midrun_next_board: got %h expected %h", board_out, e.board); end
    endtask

    task automatic test_start_ignored();
        int unsigned t0, dp;
        exp_t e;
        logic [63:0] b, x;
        b = 64'h0000_2010_7000_0000;
        x = life_step(life_step(life_step(b)));
        launch(b, 16'd3, x, t0);
        for (int i = 0; i < 50 && (cyc - t0) < 10; i++) step();
        start = 1'b1; board_in = ~b; gen_count = 16'd7;
        step();
        start = 1'b0;
        for (int i = 0; i < 300 && (cyc - t0) < 131; i++) step();
        n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL ignored_done_cycle: got busy=%b done=%b expected busy=1 done=0", busy, done); end
        start = 1'b1; board_in = 64'hFFFF_0000_FFFF_0000; gen_count = 16'd2;
        step();
        start = 1'b0;
        dp = done_pulses;
        e  = sb.pop_front();
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL ignored_done: got %b expected 1 at latency %0d", done, e.lat); end
        n_cmp++; if (board_out !== e.board) begin n_bad++; $display("FAIL ignored_board: got %h expected %h", board_out, e.board); end
        for (int i = 0; i < 300; i++) step();
        n_cmp++; if (done_pulses !== dp) begin n_bad++; $display("FAIL ignored_extra_done: got %0d expected %0d", done_pulses, dp); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ignored_busy: got %b expected 0", busy); end
        n_cmp++; if (overlap !== 0) begin n_bad++; $display("FAIL busy_done_overlap: got %0d expected 0", overlap); end
    endtask

    initial begin
        test_reset();
        test_blinker();
        test_zero_gen();
        test_block();
        test_random();
        test_reset_mid_run();
        test_start_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
